// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
//   Key-press responder for a 4x4 active-low keypad matrix. It sits on the
//   keypad side of the matrix. It pulls the selected row low while the
//   scanner strobes the key's column and the emulated contact is closed.
//   A press runs IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
//   When bounce_en is set, the contact chatters during the two bounce
//   windows, driven by a 16-bit LFSR.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   shift_col    column strobes from the scanner, active low
//   row          row lines to the scanner, active low, idle 4'hF
//   key_code     key to press: [3:2] row index, [1:0] column index
//   hold_cycles  stable-closed duration in cycles (0 behaves as 1)
//   bounce_en    1 = chatter in the bounce windows
//   press_valid  press request
//   press_ready  high only in IDLE
//   busy         high outside IDLE
//   contact      emulated contact state (1 = closed)
//   done         one-cycle pulse on the last GAP cycle
module keypad_matrix_emulator #(
   parameter int unsigned BOUNCE_CYCLES = 64,
   parameter int unsigned GAP_CYCLES    = 32,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  shift_col,
   output logic [3:0]  row,
   input  logic [3:0]  key_code,
   input  logic [15:0] hold_cycles,
   input  logic        bounce_en,
   input  logic        press_valid,
   output logic        press_ready,
   output logic        busy,
   output logic        contact,
   output logic        done
);

   localparam int unsigned MAX_BG = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
   localparam int unsigned MAXV   = (MAX_BG < 1) ? 1 : MAX_BG;
   localparam int unsigned CW     = $clog2(MAXV + 1);
   localparam logic [CW-1:0] B_LAST = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
   localparam logic [CW-1:0] G_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 0);
   localparam bit GAP_ONE    = (GAP_CYCLES <= 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BOUNCE_IN,
      S_HOLD,
      S_BOUNCE_OUT,
      S_GAP
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   hold_cnt_q;
   logic [15:0]   hold_q;
   logic [3:0]    key_q;
   logic [15:0]   lfsr_q;
   logic [15:0]   lfsr_d;
   logic [15:0]   hold_last;
   logic          contact_q;
   logic          busy_q;
   logic          done_q;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
   assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
   assign hold_last = (hold_q == '0) ? '0 : hold_q - 16'd1;

   // contact_q is always loaded with the value for the cycle being entered.
   // In the bounce windows, the LFSR advances on the same edge, so during
   // any bounce cycle contact equals lfsr_q[0].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         hold_cnt_q <= '0;
         hold_q     <= '0;
         key_q      <= '0;
         lfsr_q     <= LFSR_SEED;
         contact_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (press_valid) begin
                  key_q      <= key_code;
                  hold_q     <= hold_cycles;
                  cnt_q      <= '0;
                  hold_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  if (HAS_BOUNCE) begin
                     state_q   <= S_BOUNCE_IN;
                     lfsr_q    <= lfsr_d;
                     contact_q <= bounce_en ? lfsr_d[0] : 1'b1;
                  end else begin
                     state_q   <= S_HOLD;
                     contact_q <= 1'b1;
                  end
               end
            end
            S_BOUNCE_IN: begin
               if (cnt_q == B_LAST) begin
                  state_q    <= S_HOLD;
                  hold_cnt_q <= '0;
                  contact_q  <= 1'b1;
               end else begin
                  cnt_q     <= cnt_q + CW'(1);
                  lfsr_q    <= lfsr_d;
                  contact_q <= bounce_en ? lfsr_d[0] : 1'b1;
               end
            end
            S_HOLD: begin
               if (hold_cnt_q == hold_last) begin
                  cnt_q <= '0;
                  if (HAS_BOUNCE) begin
                     state_q   <= S_BOUNCE_OUT;
                     lfsr_q    <= lfsr_d;
                     contact_q <= bounce_en ? lfsr_d[0] : 1'b0;
                  end else begin
                     state_q   <= S_GAP;
                     contact_q <= 1'b0;
                     done_q    <= GAP_ONE;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 16'd1;
               end
            end
            S_BOUNCE_OUT: begin
               if (cnt_q == B_LAST) begin
                  state_q   <= S_GAP;
                  cnt_q     <= '0;
                  contact_q <= 1'b0;
                  done_q    <= GAP_ONE;
               end else begin
                  cnt_q     <= cnt_q + CW'(1);
                  lfsr_q    <= lfsr_d;
                  contact_q <= bounce_en ? lfsr_d[0] : 1'b0;
               end
            end
            S_GAP: begin
               contact_q <= 1'b0;
               if (cnt_q == G_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CW'(1);
                  // done is registered, so raise it when entering the last GAP cycle
                  done_q <= ((cnt_q + CW'(1)) == G_LAST);
               end
            end
            default: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               contact_q <= 1'b0;
            end
         endcase
      end
   end

   // Row lines follow the column strobes with no added latency.
   always_comb begin
      row = 4'hF;
      if (contact_q && !shift_col[key_q[1:0]]) begin
         row[key_q[3:2]] = 1'b0;
      end
   end

   assign contact     = contact_q;
   assign busy        = busy_q;
   assign press_ready = ~busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
module tb_keypad_matrix_emulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // instance A: short windows, no chatter
   logic [3:0]  a_shift_col, a_row, a_key;
   logic [15:0] a_hold;
   logic        a_ben, a_pv, a_pr, a_busy, a_contact, a_done;

   // instance B: default windows, chatter enabled
   logic [3:0]  b_shift_col, b_row, b_key;
   logic [15:0] b_hold;
   logic        b_ben, b_pv, b_pr, b_busy, b_contact, b_done;

   keypad_matrix_emulator #(.BOUNCE_CYCLES(4), .GAP_CYCLES(2), .LFSR_SEED(16'hACE1)) u_a (
      .clk(clk), .reset(rst_n), .shift_col(a_shift_col), .row(a_row),
      .key_code(a_key), .hold_cycles(a_hold), .bounce_en(a_ben),
      .press_valid(a_pv), .press_ready(a_pr), .busy(a_busy),
      .contact(a_contact), .done(a_done)
   );

   keypad_matrix_emulator #(.BOUNCE_CYCLES(64), .GAP_CYCLES(32), .LFSR_SEED(16'hACE1)) u_b (
      .clk(clk), .reset(rst_n), .shift_col(b_shift_col), .row(b_row),
      .key_code(b_key), .hold_cycles(b_hold), .bounce_en(b_ben),
      .press_valid(b_pv), .press_ready(b_pr), .busy(b_busy),
      .contact(b_contact), .done(b_done)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  seq [4];
      logic [3:0]  exp_row;
      logic [15:0] m;
      logic        exp_c, prev_c;
      int unsigned tog_in, tog_out, waited;

      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      rst_n       = 1'b0;
      a_shift_col = 4'hF; a_key = '0; a_hold = '0; a_ben = 1'b0; a_pv = 1'b0;
      b_shift_col = 4'hF; b_key = '0; b_hold = '0; b_ben = 1'b0; b_pv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_row", a_row, 4'hF);
      check("rst_contact", a_contact, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_ready", a_pr, 1);
      rst_n = 1'b1;
      tick();

      // Steady column strobe, bounce disabled
      a_key = 4'b1001; a_hold = 16'd10; a_shift_col = 4'b1101; a_ben = 1'b0; a_pv = 1'b1;
      check("t2_row_c0", a_row, 4'hF);
      tick();
      a_pv = 1'b0; a_key = 4'h0; a_hold = 16'd99;   // must be ignored after capture
      for (int i = 1; i <= 22; i++) begin
         check($sformatf("t2_row_c%0d", i), a_row, (i <= 14) ? 4'b1011 : 4'hF);
         check($sformatf("t2_done_c%0d", i), a_done, (i == 20) ? 1 : 0);
         check($sformatf("t2_ready_c%0d", i), a_pr, (i >= 21) ? 1 : 0);
         tick();
      end

      // Rotating column strobe
      a_key = 4'b1001; a_hold = 16'd10; a_shift_col = 4'b1101; a_pv = 1'b1;
      tick();
      a_pv = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         a_shift_col = seq[i % 4];
         #1;
         exp_row = ((i <= 14) && (seq[i % 4] == 4'b1101)) ? 4'b1011 : 4'hF;
         check($sformatf("t3_row_c%0d", i), a_row, exp_row);
         tick();
      end
      a_shift_col = 4'b1101;

      // Zero hold and a request while busy
      a_hold = 16'd0; a_pv = 1'b1;
      tick();
      a_pv = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 2) a_pv = 1'b1;
         if (i == 4) a_pv = 1'b0;
         check($sformatf("t5_contact_c%0d", i), a_contact, (i <= 5) ? 1 : 0);
         check($sformatf("t5_done_c%0d", i), a_done, (i == 11) ? 1 : 0);
         tick();
      end
      check("t5_ready_end", a_pr, 1);

      // Back-to-back presses with press_valid held high
      a_hold = 16'd3; a_pv = 1'b1;
      tick();
      tog_out = 0;
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("t6_busy_c%0d", i), a_busy, (i == 14) ? 0 : 1);
         check($sformatf("t6_contact_c%0d", i), a_contact, ((i <= 7) || (i >= 15)) ? 1 : 0);
         if (i >= 8 && i <= 14 && a_contact == 1'b0) tog_out++;
         if (i == 13) check("t6_done_c13", a_done, 1);
         tick();
      end
      check("t6_open_cycles", tog_out, 7);
      a_pv = 1'b0;
      waited = 0;
      while (a_pr !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      check("t6_idle_after", a_pr, 1);

      // Reset in the middle of HOLD
      a_key = 4'h5; a_hold = 16'd20; a_shift_col = 4'b1101; a_pv = 1'b1;
      tick();
      a_pv = 1'b0;
      repeat (7) tick();
      check("t1_row_hold", a_row, 4'b1101);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_row_rst", a_row, 4'hF);
      check("t1_contact_rst", a_contact, 0);
      check("t1_busy_rst", a_busy, 0);
      check("t1_ready_rst", a_pr, 1);
      check("t1_lfsr_rst", u_a.lfsr_q, 16'hACE1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t1_ready_after", a_pr, 1);
      check("t1_contact_after", a_contact, 0);
      check("t1_row_after", a_row, 4'hF);
      check("t1_lfsr_after", u_a.lfsr_q, 16'hACE1);

      // Chatter against a reference LFSR
      b_ben = 1'b1; b_hold = 16'd8; b_key = 4'h0; b_shift_col = 4'b1110; b_pv = 1'b1;
      m = 16'hACE1;
      tick();
      b_pv = 1'b0;
      tog_in = 0; tog_out = 0; prev_c = 1'b0;
      for (int i = 1; i <= 180; i++) begin
         if (i <= 64) begin
            m = lfsr_step(m);
            exp_c = m[0];
         end else if (i <= 72) begin
            exp_c = 1'b1;
         end else if (i <= 136) begin
            m = lfsr_step(m);
            exp_c = m[0];
         end else begin
            exp_c = 1'b0;
         end
         check($sformatf("t4_contact_c%0d", i), b_contact, exp_c);
         check($sformatf("t4_row_c%0d", i), b_row, exp_c ? 4'hE : 4'hF);
         check($sformatf("t4_done_c%0d", i), b_done, (i == 168) ? 1 : 0);
         if (i >= 2 && i <= 64 && b_contact != prev_c) tog_in++;
         if (i >= 74 && i <= 136 && b_contact != prev_c) tog_out++;
         prev_c = b_contact;
         tick();
      end
      check("t4_toggle_in", (tog_in >= 1) ? 1 : 0, 1);
      check("t4_toggle_out", (tog_out >= 1) ? 1 : 0, 1);
      check("t4_ready_end", b_pr, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
